univ_reg_preset_clear: RTL and testbench
========================================

// Module: univ_reg_preset_clear
// PURPOSE
//  Parametrised universal register. Successor to the single-bit clocked D latch with preset/clear.
//  Holds WIDTH bits and supports hold, parallel load, shift, rotate and up/down count modes.
//  Keeps the clear/preset controls and the complementary q/qnot outputs.
//  Used as the general storage/shift/count element in lab datapaths.
//  Fully synchronous: every state change happens on the clk rising edge.
// PARAMETERS
//  WIDTH       8                 register width in bits; legal range WIDTH >= 2
//  RESET_VAL   {WIDTH{1'b0}}     value loaded into q by rst_n
//  PRESET_VAL  {WIDTH{1'b1}}     value loaded into q by pre
// PORTS
//  clk    in   1      rising-edge clock
//  rst_n  in   1      synchronous active-low reset
//  clr    in   1      synchronous clear, active high
//  pre    in   1      synchronous preset, active high
//  en     in   1      operation enable; en=0 holds all state
//  mode   in   3      operation select (see BEHAVIOUR)
//  d      in   WIDTH  parallel load data
//  sin    in   1      serial input for shift modes
//  q      out  WIDTH  register contents
//  qnot   out  WIDTH  bitwise complement of q
//  sout   out  1      registered bit shifted/rotated out
//  tc     out  1      terminal-count pulse (count wrap)
// BEHAVIOUR
//  - All outputs are registered and update only on the rising edge of clk. No combinational path from inputs to outputs.
//  - Priority per edge: rst_n=0 > clr=1 > pre=1 > en=0 > mode.
//  - rst_n=0: q=RESET_VAL, qnot=~RESET_VAL, sout=0, tc=0.
//  - clr=1: q=0, qnot=all ones, sout=0, tc=0. pre is ignored when clr=1.
//  - pre=1 (clr=0): q=PRESET_VAL, qnot=~PRESET_VAL, sout=0, tc=0.
//  - en=0: q, qnot and sout hold; tc=0.
//  - Modes with en=1 (q' is the next q):
//    000 HOLD : q'=q
//    001 LOAD : q'=d
//    010 SHL  : q'={q[W-2:0],sin}; sout'=q[W-1]
//    011 SHR  : q'={sin,q[W-1:1]}; sout'=q[0]
//    100 ROL  : q'={q[W-2:0],q[W-1]}; sout'=q[W-1]
//    101 ROR  : q'={q[0],q[W-1:1]}; sout'=q[0]
//    110 UP   : q'=(q+1) mod 2^W; tc'=1 iff q was all ones
//    111 DOWN : q'=(q-1) mod 2^W; tc'=1 iff q was 0
//  - sout changes only in the shift/rotate modes (010-101) and on rst/clr/pre. In every other mode it holds.
//  - tc is a single-cycle pulse. It is 0 on every edge that is not a wrapping UP/DOWN step.
//  - Count arithmetic is unsigned WIDTH-bit and wraps silently; tc is the only overflow/underflow indication.
//  - Invariant: qnot == ~q after every edge, including the reset edge.
//  - Reset asserted mid-operation (for example mid-count) takes effect on that edge. No partial result is kept.
//  - Latency: one clk edge from the input change to the corresponding q/qnot/sout/tc.
// TESTING
//  1. rst_n=0 for 2 edges, then release -> q=8'h00, qnot=8'hFF, sout=0, tc=0.
//  2. LOAD d=8'hA5, then SHL with sin=1 -> q=8'h4B, qnot=8'hB4, sout=1.
//     ROR from 8'h4B -> q=8'hA5, sout=1.
//  3. LOAD 8'hFE, then UP for 3 edges -> q=FF (tc=0), 00 (tc=1), 01 (tc=0).
//     DOWN from 8'h00 -> q=8'hFF, tc=1 for exactly one cycle.
//  4. clr=1 and pre=1 together with en=1, mode=LOAD, d=8'h3C -> q=8'h00 (clr wins).
//     Then pre=1 alone -> q=8'hFF, qnot=8'h00.
//  5. en=0 with mode=UP and sin toggling for 5 edges -> q, qnot and sout unchanged, tc=0.
//  6. Counting UP from 8'h10, drop rst_n on the 3rd edge -> q=8'h00 on that edge; counting resumes from 0 after release.

Source files
------------

// File: rtl/univ_reg_preset_clear.sv
// univ_reg_preset_clear
// WIDTH-bit universal register with hold, parallel load, shift, rotate and
// up/down count. Synchronous reset, clear and preset are included, as are
// complementary outputs. Every output comes from a flop, so no input reaches
// an output combinationally. The only changes happen on the rising edge of clk.
//
// Control priority on each edge: rst_n low, then clr, then pre, then en low,
// then mode.
//
// This block has no handshake. Each edge applies exactly one operation,
// and that operation is chosen by the priority chain above.

module univ_reg_preset_clear #(
    parameter int unsigned      WIDTH      = 8,
    parameter logic [WIDTH-1:0] RESET_VAL  = {WIDTH{1'b0}},
    parameter logic [WIDTH-1:0] PRESET_VAL = {WIDTH{1'b1}}
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             clr,
    input  logic             pre,
    input  logic             en,
    input  logic [2:0]       mode,
    input  logic [WIDTH-1:0] d,
    input  logic             sin,
    output logic [WIDTH-1:0] q,
    output logic [WIDTH-1:0] qnot,
    output logic             sout,
    output logic             tc
);

    // Operation encodings presented on the mode input.
    typedef enum logic [2:0] {
        MODE_HOLD = 3'b000,
        MODE_LOAD = 3'b001,
        MODE_SHL  = 3'b010,
        MODE_SHR  = 3'b011,
        MODE_ROL  = 3'b100,
        MODE_ROR  = 3'b101,
        MODE_UP   = 3'b110,
        MODE_DOWN = 3'b111
    } mode_e;

    localparam logic [WIDTH-1:0] ALL_ONES  = {WIDTH{1'b1}};
    localparam logic [WIDTH-1:0] ALL_ZEROS = {WIDTH{1'b0}};
    localparam logic [WIDTH-1:0] ONE       = {{(WIDTH-1){1'b0}}, 1'b1};

    // State registers. qnot has its own flop so that it is truly registered.
    // It is always loaded with the complement of the q_next value.
    logic [WIDTH-1:0] q_r;
    logic [WIDTH-1:0] qnot_r;
    logic             sout_r;
    logic             tc_r;

    // Next-state values for the mode datapath (the en=1 path only).
    logic [WIDTH-1:0] q_mode;
    logic             sout_mode;
    logic             tc_mode;

    // Next-state values after the control priority chain is applied.
    logic [WIDTH-1:0] q_next;
    logic             sout_next;
    logic             tc_next;

    mode_e mode_sel;

    assign mode_sel = mode_e'(mode);

    // Mode datapath. Compute the result of the selected operation from the
    // current q. sout and tc hold or clear unless the mode drives them.
    always_comb begin
        q_mode    = q_r;
        sout_mode = sout_r;
        tc_mode   = 1'b0;
        unique case (mode_sel)
            MODE_HOLD: begin
                q_mode = q_r;
            end
            MODE_LOAD: begin
                q_mode = d;
            end
            MODE_SHL: begin
                q_mode    = {q_r[WIDTH-2:0], sin};
                sout_mode = q_r[WIDTH-1];
            end
            MODE_SHR: begin
                q_mode    = {sin, q_r[WIDTH-1:1]};
                sout_mode = q_r[0];
            end
            MODE_ROL: begin
                q_mode    = {q_r[WIDTH-2:0], q_r[WIDTH-1]};
                sout_mode = q_r[WIDTH-1];
            end
            MODE_ROR: begin
                q_mode    = {q_r[0], q_r[WIDTH-1:1]};
                sout_mode = q_r[0];
            end
            MODE_UP: begin
                // Arithmetic wraps modulo 2^WIDTH. tc flags the wrap.
                q_mode  = q_r + ONE;
                tc_mode = (q_r == ALL_ONES);
            end
            MODE_DOWN: begin
                q_mode  = q_r - ONE;
                tc_mode = (q_r == ALL_ZEROS);
            end
            default: begin
                q_mode = q_r;
            end
        endcase
    end

    // Control priority chain: reset, then clear, then preset, then enable.
    // The mode datapath result is used only when nothing above it is active.
    always_comb begin
        q_next    = q_r;
        sout_next = sout_r;
        tc_next   = 1'b0;
        if (!rst_n) begin
            q_next    = RESET_VAL;
            sout_next = 1'b0;
        end else if (clr) begin
            q_next    = ALL_ZEROS;
            sout_next = 1'b0;
        end else if (pre) begin
            q_next    = PRESET_VAL;
            sout_next = 1'b0;
        end else if (!en) begin
            q_next    = q_r;
            sout_next = sout_r;
        end else begin
            q_next    = q_mode;
            sout_next = sout_mode;
            tc_next   = tc_mode;
        end
    end

    // State update. The synchronous reset is folded into q_next above, so
    // this block simply loads every register on each rising edge.
    always_ff @(posedge clk) begin
        q_r    <= q_next;
        qnot_r <= ~q_next;
        sout_r <= sout_next;
        tc_r   <= tc_next;
    end

    assign q    = q_r;
    assign qnot = qnot_r;
    assign sout = sout_r;
    assign tc   = tc_r;

endmodule

// File: tb/tb_univ_reg_preset_clear.sv
// Bench for univ_reg_preset_clear (WIDTH=8). It runs directed scenarios
// first and then randomized cycles. A behavioural model predicts every edge,
// and the expected q values pass through a scoreboard queue.

module tb_univ_reg_preset_clear;

    localparam int W = 8;

    // Clock and reset block.
    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic          rst_n = 1'b0;
    logic          clr   = 1'b0;
    logic          pre   = 1'b0;
    logic          en    = 1'b0;
    logic [2:0]    mode  = 3'b000;
    logic [W-1:0]  d     = '0;
    logic          sin   = 1'b0;
    logic [W-1:0]  q;
    logic [W-1:0]  qnot;
    logic          sout;
    logic          tc;

    univ_reg_preset_clear #(.WIDTH(W)) dut (
        .clk  (clk),
        .rst_n(rst_n),
        .clr  (clr),
        .pre  (pre),
        .en   (en),
        .mode (mode),
        .d    (d),
        .sin  (sin),
        .q    (q),
        .qnot (qnot),
        .sout (sout),
        .tc   (tc)
    );

    int tests_run = 0;
    int tests_failed = 0;

    // Reference model state, held as plain integers.
    int m_q    = 0;
    int m_sout = 0;
    int m_tc   = 0;

    logic [W-1:0] exp_q[$];

    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests_run++;
        if (obs !== exp) begin
            tests_failed++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Model one edge from the rules, using integer arithmetic modulo 256.
    task automatic model_step();
        int s;
        s = sin ? 1 : 0;
        if (!rst_n || clr) begin
            m_q = 0; m_sout = 0; m_tc = 0;
        end else if (pre) begin
            m_q = 255; m_sout = 0; m_tc = 0;
        end else if (!en) begin
            m_tc = 0;
        end else begin
            m_tc = 0;
            case (mode)
                3'd0: ;
                3'd1: m_q = int'(d);
                3'd2: begin m_sout = m_q / 128; m_q = (m_q * 2) % 256 + s; end
                3'd3: begin m_sout = m_q % 2;   m_q = m_q / 2 + s * 128; end
                3'd4: begin m_sout = m_q / 128; m_q = (m_q * 2) % 256 + m_q / 128; end
                3'd5: begin m_sout = m_q % 2;   m_q = m_q / 2 + (m_q % 2) * 128; end
                3'd6: begin m_tc = (m_q == 255); m_q = (m_q + 1) % 256; end
                default: begin m_tc = (m_q == 0); m_q = (m_q + 255) % 256; end
            endcase
        end
    endtask

    // Driver: apply the inputs, clock one edge, then compare the DUT against the model.
    task automatic drive(input logic r, input logic c, input logic p, input logic e,
                         input logic [2:0] m, input logic [W-1:0] dv, input logic s);
        logic [W-1:0] eq;
        rst_n = r; clr = c; pre = p; en = e; mode = m; d = dv; sin = s;
        @(posedge clk);
        model_step();
        exp_q.push_back(W'(m_q));
        #1;
        eq = exp_q.pop_front();
        check_val("q", {24'h0, q}, {24'h0, eq});
        check_val("qnot", {24'h0, qnot}, {24'h0, ~eq});
        check_val("sout", {31'h0, sout}, 32'(m_sout));
        check_val("tc", {31'h0, tc}, 32'(m_tc));
    endtask

    initial begin
        logic [W-1:0] q_save;
        logic         s_save;

        // 1: reset for two edges, then release.
        drive(0, 0, 0, 0, 3'd0, 8'h00, 0);
        drive(0, 0, 0, 0, 3'd0, 8'h00, 0);
        drive(1, 0, 0, 0, 3'd0, 8'h00, 0);
        check_val("t1_q", {24'h0, q}, 32'h00);
        check_val("t1_qnot", {24'h0, qnot}, 32'hFF);
        check_val("t1_sout", {31'h0, sout}, 32'h0);
        check_val("t1_tc", {31'h0, tc}, 32'h0);

        // 2: load, shift left, rotate right.
        drive(1, 0, 0, 1, 3'd1, 8'hA5, 0);
        drive(1, 0, 0, 1, 3'd2, 8'h00, 1);
        check_val("t2_shl_q", {24'h0, q}, 32'h4B);
        check_val("t2_shl_qnot", {24'h0, qnot}, 32'hB4);
        check_val("t2_shl_sout", {31'h0, sout}, 32'h1);
        drive(1, 0, 0, 1, 3'd5, 8'h00, 0);
        check_val("t2_ror_q", {24'h0, q}, 32'hA5);
        check_val("t2_ror_sout", {31'h0, sout}, 32'h1);

        // 3: count up across the wrap, then count down from zero.
        drive(1, 0, 0, 1, 3'd1, 8'hFE, 0);
        drive(1, 0, 0, 1, 3'd6, 8'h00, 0);
        check_val("t3_up1", {23'h0, tc, q}, 32'h0FF);
        drive(1, 0, 0, 1, 3'd6, 8'h00, 0);
        check_val("t3_up2", {23'h0, tc, q}, 32'h100);
        drive(1, 0, 0, 1, 3'd6, 8'h00, 0);
        check_val("t3_up3", {23'h0, tc, q}, 32'h001);
        drive(1, 0, 0, 1, 3'd1, 8'h00, 0);
        drive(1, 0, 0, 1, 3'd7, 8'h00, 0);
        check_val("t3_dn1", {23'h0, tc, q}, 32'h1FF);
        drive(1, 0, 0, 1, 3'd0, 8'h00, 0);
        check_val("t3_dn_pulse", {31'h0, tc}, 32'h0);

        // 4: clear beats preset and load; then preset alone.
        drive(1, 1, 1, 1, 3'd1, 8'h3C, 0);
        check_val("t4_clr_q", {24'h0, q}, 32'h00);
        drive(1, 0, 1, 1, 3'd1, 8'h3C, 0);
        check_val("t4_pre_q", {24'h0, q}, 32'hFF);
        check_val("t4_pre_qnot", {24'h0, qnot}, 32'h00);

        // 5: en=0 holds q, qnot and sout while sin toggles.
        drive(1, 0, 0, 1, 3'd1, 8'h5A, 0);
        drive(1, 0, 0, 1, 3'd3, 8'h00, 1);
        q_save = q; s_save = sout;
        for (int i = 0; i < 5; i++) begin
            drive(1, 0, 0, 0, 3'd6, 8'h00, i[0]);
            check_val("t5_hold_q", {24'h0, q}, {24'h0, q_save});
            check_val("t5_hold_qnot", {24'h0, qnot}, {24'h0, ~q_save});
            check_val("t5_hold_sout", {31'h0, sout}, {31'h0, s_save});
            check_val("t5_hold_tc", {31'h0, tc}, 32'h0);
        end

        // 6: reset during counting takes effect at once; counting then resumes from 0.
        drive(1, 0, 0, 1, 3'd1, 8'h10, 0);
        drive(1, 0, 0, 1, 3'd6, 8'h00, 0);
        drive(1, 0, 0, 1, 3'd6, 8'h00, 0);
        check_val("t6_cnt", {24'h0, q}, 32'h12);
        drive(0, 0, 0, 1, 3'd6, 8'h00, 0);
        check_val("t6_rst_q", {24'h0, q}, 32'h00);
        drive(1, 0, 0, 1, 3'd6, 8'h00, 0);
        check_val("t6_resume", {24'h0, q}, 32'h01);

        // Randomized cycles. Reset, clear and preset are kept rare so the modes dominate.
        for (int i = 0; i < 600; i++) begin
            drive(($urandom_range(0, 39) != 0),
                  ($urandom_range(0, 29) == 0),
                  ($urandom_range(0, 24) == 0),
                  ($urandom_range(0, 7) != 0),
                  3'($urandom_range(0, 7)),
                  8'($urandom_range(0, 255)),
                  1'($urandom_range(0, 1)));
        end

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
